// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC decoder core: controller state encoding
// and default sizing constants used by the controller and the node arrays.
package ldpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CNU   = 3'd2,
        ST_VNU   = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } ldpc_state_t;

    localparam int MAX_ITER_DEF = 8;
    localparam int CNU_LAT_DEF  = 2;
    localparam int N_CHK_DEF    = 6;
    localparam int LLR_W        = 32;

endpackage

// File: rtl/ldpc_phase_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero, marking
// the last cycle of a timed datapath phase.
module ldpc_phase_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          en_i,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// LDPC iteration controller: sequences load / CNU / VNU / syndrome-check phases,
// stopping on a zero syndrome or when the iteration budget runs out.
module ldpc_iter_ctrl
    import ldpc_pkg::*;
#(
    parameter int  MAX_ITER = MAX_ITER_DEF,
    parameter int  CNU_LAT  = CNU_LAT_DEF,
    parameter int  N_CHK    = N_CHK_DEF,
    localparam int ITW      = $clog2(MAX_ITER + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic             abort,
    input  logic [N_CHK-1:0] syndrome,
    output logic             dec_load,
    output logic             cnu_en,
    output logic             vnu_en,
    output logic [ITW-1:0]   iter_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             success
);

    localparam int             TW       = $clog2(CNU_LAT + 1);
    localparam logic [TW-1:0]  CNU_LOAD = TW'(CNU_LAT - 1);
    localparam logic [ITW-1:0] ITER_MAX = ITW'(MAX_ITER);

    ldpc_state_t    state_q, state_d;
    logic [ITW-1:0] iter_q, iter_d;
    logic           succ_q, succ_d;
    logic           tmr_load, tmr_en, tmr_tc;
    logic           syn_zero;

    assign syn_zero = ~|syndrome;

    ldpc_phase_timer #(.CW(TW)) u_cnu_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (CNU_LOAD),
        .en_i       (tmr_en),
        .tc_o       (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        succ_d   = succ_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    iter_d  = '0;
                    succ_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                state_d  = ST_CNU;
                tmr_load = 1'b1;
            end
            ST_CNU: begin
                tmr_en = 1'b1;
                if (tmr_tc) state_d = ST_VNU;
            end
            ST_VNU: begin
                state_d = ST_CHECK;
                if (iter_q != ITER_MAX) iter_d = iter_q + ITW'(1);
            end
            ST_CHECK: begin
                if (syn_zero) begin
                    state_d = ST_DONE;
                    succ_d  = 1'b1;
                end else if (iter_q == ITER_MAX) begin
                    state_d = ST_DONE;
                    succ_d  = 1'b0;
                end else begin
                    state_d  = ST_CNU;
                    tmr_load = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // An aborted frame keeps the iterations it has already completed.
        if (abort && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            state_d  = ST_IDLE;
            iter_d   = iter_q;
            succ_d   = succ_q;
            tmr_load = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            iter_q  <= '0;
            succ_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            succ_q  <= succ_d;
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign dec_load  = (state_q == ST_LOAD);
    assign cnu_en    = (state_q == ST_CNU);
    assign vnu_en    = (state_q == ST_VNU);
    assign out_valid = (state_q == ST_DONE);
    assign success   = succ_q;
    assign iter_cnt  = iter_q;

endmodule

// File: doc/ldpc_iter_ctrl.md
Name: ldpc_iter_ctrl

Overview:
Iteration controller for the LDPC decoder core. It sequences the check-node (CNU) and variable-node (VNU) arrays through load, CNU, VNU and syndrome-check phases. It terminates early when the syndrome is all-zero, or when the iteration budget is exhausted. It presents a start/ready handshake upstream and a valid/ready result handshake downstream; the datapath arrays are pure slaves of its enable strobes.

Parameters:
MAX_ITER, 8, maximum decoding iterations (≥1)
CNU_LAT, 2, cycles the CNU array needs per phase (≥1)
N_CHK, 6, number of check equations (syndrome width)
ITW, $clog2(MAX_ITER+1), iteration counter width (derived, not overridable)

Ports:
clk  in  1  rising-edge clock, shared with the VNU/CNU arrays
rst  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  request to decode the frame whose channel LLRs are present on the arrays' L inputs
ready  out  1  controller idle; start accepted on the cycle start&&ready
abort  in  1  cancel the decode in progress; return to IDLE
syndrome  in  N_CHK  per-check parity of current VNU hard decisions (P bits); 0 = codeword valid
dec_load  out  1  VNU arrays load L into P_sample/Q (init strobe)
cnu_en  out  1  CNU arrays compute R from Q
vnu_en  out  1  VNU arrays update P_sample/Q from R and L
iter_cnt  out  ITW  completed iterations of the current/last frame
out_valid  out  1  decode result available
out_ready  in  1  downstream accepts the result
success  out  1  valid with out_valid: 1 = syndrome zero, 0 = budget exhausted

Behaviour:
- Reset (rst=0, async): state=IDLE, phase counter=0, iter_cnt=0, success=0. All strobes=0, out_valid=0, ready=1.
- Outputs are Moore: decoded only from the state, counter and flag registers; no input-to-output combinational path.
- States: IDLE, LOAD, CNU, VNU, CHECK, DONE.
- IDLE: ready=1. On start=1 → LOAD; iter_cnt←0, success←0.
- LOAD: dec_load=1 for exactly 1 cycle → CNU; phase counter←0.
- CNU: cnu_en=1 for exactly CNU_LAT consecutive cycles (phase counter 0..CNU_LAT-1) → VNU.
- VNU: vnu_en=1 for 1 cycle → CHECK. iter_cnt increments on exit, saturating at MAX_ITER.
- CHECK: 1 cycle; syndrome is sampled only here.
  - syndrome==0 → DONE, success←1.
  - else if iter_cnt==MAX_ITER → DONE, success←0.
  - else → CNU.
- DONE: out_valid=1. success and iter_cnt are held stable until out_valid&&out_ready, then → IDLE. out_valid is never dropped without a handshake.
- Latency from the start-accept edge to out_valid: 1 + I×(CNU_LAT+2) cycles, where I = iterations run. With defaults, I=1 gives 5 and I=8 gives 33.
- abort=1 in any state other than IDLE or DONE → IDLE next edge. No out_valid is produced; iter_cnt keeps its partial count.
- abort in IDLE or DONE is ignored; a pending result is not discarded.
- start while not IDLE is ignored (ready=0); it is not queued.
- abort and start high together in IDLE: start wins.
- Syndrome X/changes outside CHECK have no effect.
- Reset mid-frame: immediate return to the reset values; the datapath contents are don't-care.
- Strobes dec_load, cnu_en and vnu_en are mutually exclusive in every cycle.

Decomposition:
- Shared package ldpc_pkg: state enumeration (3-bit encoding), default constants MAX_ITER_DEF=8, CNU_LAT_DEF=2, N_CHK_DEF=6, and the shared LLR width constant (32) used by the VNU/CNU arrays.
- One natural sub-module: ldpc_phase_timer, a loadable down-counter with a terminal pulse. It times the CNU phase and is reusable if VNU latency grows.
- Syndrome reduction (NOR over N_CHK) stays inline.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release → ready=1, all strobes 0, out_valid=0, iter_cnt=0.
- Early termination: start for 1 cycle, syndrome=0 → dec_load at cycle 1, cnu_en cycles 2–3, vnu_en cycle 4, CHECK cycle 5. out_valid from cycle 6 with success=1, iter_cnt=1.
- Budget exhaustion: syndrome=6'b000101 constant → 8 VNU pulses. out_valid with success=0, iter_cnt=8, 33 cycles after the start-accept edge.
- Converge at iteration 3: syndrome nonzero in the first two CHECKs, 0 in the third → success=1, iter_cnt=3. Count exactly 3 vnu_en and 6 cnu_en pulses.
- Backpressure and abort: hold out_ready=0 for 10 cycles in DONE → out_valid, success and iter_cnt stable, and a start pulse is ignored. Separately, abort during the 2nd CNU phase → IDLE next cycle, no out_valid.
- Async reset mid-VNU: drive rst=0 between clock edges → strobes drop immediately, ready=1 after release. A new start then decodes normally.
